// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA engine: on a $4014 write it halts the CPU, takes the bus, and copies
// one 256-byte CPU page to the PPU OAM data port using alternating get/put cycles.
module nes_oam_dma #(
    parameter int               ADDR_W        = 16,
    parameter int               DATA_W        = 8,
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic              clk,
    input  logic              b_rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_halted,
    output logic              cpu_halt,
    output logic              dma_active,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              dma_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        ALIGN     = 3'd2,
        READ      = 3'd3,
        WRITE     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              parity_q, parity_d;
    logic [7:0]        idx_q, idx_d;
    logic [DATA_W-1:0] page_q, page_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              cpu_halt_q, cpu_halt_d;
    logic              dma_active_q, dma_active_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_we_q, bus_we_d;
    logic              dma_done_q, dma_done_d;

    // State, parity and transfer bookkeeping registers.
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            idx_q    <= 8'd0;
            page_q   <= {DATA_W{1'b0}};
            data_q   <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            data_q   <= data_d;
        end
    end

    // Next-state logic: parity 0 is a get cycle, parity 1 a put cycle.
    always_comb begin
        state_d  = state_q;
        parity_d = ~parity_q;
        idx_d    = idx_q;
        page_d   = page_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'd0;
                    state_d = HALT_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT_WAIT: begin
                if (cpu_halted) begin
                    state_d = ALIGN;
                end else begin
                    state_d = HALT_WAIT;
                end
            end
            ALIGN: begin
                if (parity_q) begin
                    state_d = READ;
                end else begin
                    state_d = ALIGN;
                end
            end
            READ: begin
                data_d  = bus_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        cpu_halt_d   = (state_d != IDLE);
        dma_active_d = 1'b0;
        bus_addr_d   = {ADDR_W{1'b0}};
        bus_wdata_d  = {DATA_W{1'b0}};
        bus_we_d     = 1'b0;
        dma_done_d   = (state_q == WRITE) && (idx_q == 8'hFF);
        case (state_d)
            ALIGN: begin
                dma_active_d = 1'b1;
                bus_addr_d   = ADDR_W'({page_d, 8'h00});
            end
            READ: begin
                dma_active_d = 1'b1;
                bus_addr_d   = ADDR_W'({page_d, idx_d});
            end
            WRITE: begin
                dma_active_d = 1'b1;
                bus_addr_d   = OAM_DATA_ADDR;
                bus_wdata_d  = data_d;
                bus_we_d     = 1'b1;
            end
            default: begin
                dma_active_d = 1'b0;
                bus_addr_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            cpu_halt_q   <= 1'b0;
            dma_active_q <= 1'b0;
            bus_addr_q   <= {ADDR_W{1'b0}};
            bus_wdata_q  <= {DATA_W{1'b0}};
            bus_we_q     <= 1'b0;
            dma_done_q   <= 1'b0;
        end else begin
            cpu_halt_q   <= cpu_halt_d;
            dma_active_q <= dma_active_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_we_q     <= bus_we_d;
            dma_done_q   <= dma_done_d;
        end
    end

    assign cpu_halt   = cpu_halt_q;
    assign dma_active = dma_active_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_we     = bus_we_q;
    assign dma_done   = dma_done_q;

endmodule
